onchip_mem_arbiter: RTL and testbench
=====================================

# onchip_mem_arbiter

Two-port round-robin arbiter that shares the single-port 8000×32 on-chip RAM (13-bit word address, byte enables, 1-cycle read latency) between two Avalon-MM masters, e.g. the Nios II data master and a DMA engine. It sits between the interconnect and the RAM's s1 port. It issues at most one access per cycle and routes read data back to the owning master with `readdatavalid`.

## Interface
- `ADDR_W`, 13: word address width.
- `DATA_W`, 32: data width; byte-enable width is `DATA_W/8`.
- `DEPTH`, 8000: implemented words; used only when range checking is compiled in.

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `m0_address`, `m1_address`  in  `ADDR_W`  master word address.
- `m0_byteenable`, `m1_byteenable`  in  4  byte lanes for writes.
- `m0_read`, `m1_read`  in  1  read request.
- `m0_write`, `m1_write`  in  1  write request.
- `m0_writedata`, `m1_writedata`  in  `DATA_W`  write data.
- `m0_waitrequest`, `m1_waitrequest`  out  1  high while the request is not accepted this cycle.
- `m0_readdata`, `m1_readdata`  out  `DATA_W`  read data.
- `m0_readdatavalid`, `m1_readdatavalid`  out  1  one-cycle read-data strobe.
- `mem_address`  out  `ADDR_W`  RAM address.
- `mem_byteenable`  out  4  RAM byte enables.
- `mem_chipselect`  out  1  RAM chipselect.
- `mem_write`  out  1  RAM write.
- `mem_writedata`  out  `DATA_W`  RAM write data.
- `mem_clken`  out  1  RAM clock enable.
- `mem_readdata`  in  `DATA_W`  RAM output; unregistered, valid 1 cycle after the address.
- `range_err`  out  1  sticky out-of-range flag; 0 when range checking is compiled out.

## Operation
- A request from master *i* is `mi_read | mi_write`. If both are high, the request is a write and the read is ignored.
- Arbitration is combinational on the current requests and register `last_q`.
  - Only one master requesting: that master is granted.
  - Both requesting: the master ≠ `last_q` is granted.
  - `last_q` loads the granted index on every grant.
- `mi_waitrequest = request_i & ~grant_i`. The waitrequest of an idle master is 0.
- On grant, the mem outputs are driven combinationally from the granted master:
  - address, byteenable, writedata are passed through;
  - `mem_chipselect` = 1;
  - `mem_write` = the granted master's write.
- With no grant: `mem_chipselect` = 0, `mem_write` = 0, and the other mem outputs hold the master-0 values (don't care).
- `mem_clken` = 1 whenever `reset_n` is high.
- Read tracking registers:
  - `rdv_q` is set on a granted read.
  - `owner_q` stores the granted index.
- Cycle after a granted read: `m{owner_q}_readdatavalid` = 1 and `m{owner_q}_readdata` = `mem_readdata`. The other master's readdata = 0.
- Back-to-back reads, including alternating masters, sustain 1 read/cycle. A grant in cycle *n* and the data return for cycle *n−1* coexist.
- Writes produce no response and complete in the grant cycle.

## Timing
- Reset values, held while `reset_n` is low:
  - `last_q` = 1, so m0 wins the first tie;
  - `rdv_q` = 0, `owner_q` = 0, `range_err` = 0;
  - all `readdatavalid` = 0, all `readdata` = 0;
  - `mem_chipselect` = 0, `mem_write` = 0, `mem_clken` = 0.
- Uncontended request latency: 0 wait cycles. Contended request latency: at most 1 wait cycle (fairness bound).
- Read latency: `readdatavalid` exactly 1 cycle after the accept edge.
- Masters hold all request signals stable while `waitrequest` = 1 (Avalon rule). The arbiter does not re-check this.
- Reset asserted mid-read: the pending `readdatavalid` is dropped. After `reset_n` rises, no stale strobe appears.

## Configuration
- `MEM_ARB_RANGE_CHECK_EN` defined:
  - A granted access with address ≥ `DEPTH` is accepted normally (waitrequest behaviour unchanged) but not forwarded: `mem_chipselect` = 0, `mem_write` = 0.
  - Such a read returns 32'h0000_0000 with `readdatavalid` at the normal latency.
  - `range_err` sets on the next edge and stays set until reset.
- Not defined: the address is forwarded unchanged, and `range_err` is constant 0.

## Test plan
- Reset, then idle: all outputs at reset values. One cycle after `reset_n` rises, `mem_clken` = 1 and `mem_chipselect` = 0.
- m0 writes 0xCAFEBABE, byteenable 4'hF, to address 0x0010; m0 then reads 0x0010 → zero wait on both, and `m0_readdatavalid` one cycle after the read with `m0_readdata` = 0xCAFEBABE. m1 sees no strobe.
- m0 and m1 read simultaneously, held for 4 cycles → grants alternate m0, m1, m0, m1. Each master sees `waitrequest` high for at most 1 cycle, and each strobe carries the data of its own address.
- m1 writes byteenable 4'b0011 with data 0x12345678 over 0xFFFFFFFF at 0x0100, then reads → 0xFFFF5678.
- Assert `reset_n` low in the cycle after a granted read → no `readdatavalid` during or after reset, and the first tie after reset is won by m0.
- With `MEM_ARB_RANGE_CHECK_EN`: m0 reads address 8000 → `mem_chipselect` stays 0, `m0_readdata` = 0 with a strobe after 1 cycle, and `range_err` = 1 until reset. Without the macro, `range_err` stays 0.

Source files
------------

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two Avalon-MM masters; optional MEM_ARB_RANGE_CHECK_EN blocks out-of-range accesses.
// Latency: grant is combinational, 0 wait uncontended and at most 1 wait contended; readdatavalid 1 cycle after accept.
// Backpressure: the losing master sees waitrequest for one cycle; read data is never stalled, so reads sustain 1 per cycle.
module onchip_mem_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                range_err
);

    logic              req0, req1;
    logic              gnt0, gnt1, gnt_any, sel;
    logic              gnt_wr, gnt_rd;
    logic              fwd, oor;
    logic [DATA_W-1:0] rdata_ret;

    logic last_q;
    logic rdv_q;
    logic owner_q;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // On a tie the master that did not win last time is granted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0 && req1) begin
            gnt0 = last_q;
            gnt1 = ~last_q;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    assign gnt_any = gnt0 | gnt1;
    assign sel     = gnt1;
    assign gnt_wr  = sel ? m1_write : m0_write;
    assign gnt_rd  = gnt_any & ~gnt_wr;

    assign m0_waitrequest = req0 & ~gnt0;
    assign m1_waitrequest = req1 & ~gnt1;

    assign mem_address    = sel ? m1_address    : m0_address;
    assign mem_byteenable = sel ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = sel ? m1_writedata  : m0_writedata;
    assign mem_clken      = reset_n;
    assign mem_chipselect = fwd & reset_n;
    assign mem_write      = fwd & gnt_wr & reset_n;

    assign oor = {1'b0, mem_address} >= (ADDR_W+1)'(DEPTH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q  <= 1'b1;
            rdv_q   <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            rdv_q <= gnt_rd;
            if (gnt_any) begin
                last_q  <= sel;
                owner_q <= sel;
            end
        end
    end

`ifdef MEM_ARB_RANGE_CHECK_EN
    logic oor_q;
    logic range_err_q;

    // Out-of-range accesses are accepted but never reach the RAM.
    assign fwd = gnt_any & ~oor;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oor_q       <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            oor_q <= gnt_rd & oor;
            if (gnt_any && oor)
                range_err_q <= 1'b1;
        end
    end

    assign rdata_ret = oor_q ? '0 : mem_readdata;
    assign range_err = range_err_q;
`else
    logic unused_oor;

    assign fwd        = gnt_any;
    assign rdata_ret  = mem_readdata;
    assign range_err  = 1'b0;
    assign unused_oor = oor;
`endif

    assign m0_readdatavalid = rdv_q & ~owner_q;
    assign m1_readdatavalid = rdv_q & owner_q;
    assign m0_readdata      = m0_readdatavalid ? rdata_ret : '0;
    assign m1_readdata      = m1_readdatavalid ? rdata_ret : '0;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural single-port RAM behind it.
module tb_onchip_mem_arbiter;

    logic        clk;
    logic        reset_n;
    logic [12:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m1_read, m0_write, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        range_err;

    int total = 0;
    int bad   = 0;

    logic [31:0] ram [0:8191];

    onchip_mem_arbiter #(.ADDR_W(13), .DATA_W(32), .DEPTH(8000)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable),
        .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable),
        .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata), .range_err(range_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered address, one-cycle read latency, byte-lane writes.
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b])
                        ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) ram[i] = 32'h0;
        mem_readdata = 32'h0;
        reset_n = 0;
        idle();
        m0_address = 0; m1_address = 0;
        m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        m0_writedata = 0; m1_writedata = 0;

        // Reset state, with a request present to show outputs are held.
        repeat (3) @(posedge clk);
        #1;
        m0_read = 1; m0_address = 13'h005;
        #1;
        check("rst_cs",    mem_chipselect,   0);
        check("rst_mwr",   mem_write,        0);
        check("rst_clken", mem_clken,        0);
        check("rst_rdv0",  m0_readdatavalid, 0);
        check("rst_rdv1",  m1_readdatavalid, 0);
        check("rst_rd0",   m0_readdata,      0);
        check("rst_rd1",   m1_readdata,      0);
        check("rst_err",   range_err,        0);
        step();
        check("rst_rdv0_b", m0_readdatavalid, 0);
        idle();
        reset_n = 1;
        step();
        check("idle_clken", mem_clken,      1);
        check("idle_cs",    mem_chipselect, 0);
        check("idle_wait0", m0_waitrequest, 0);
        check("idle_wait1", m1_waitrequest, 0);

        // m0 write then read back.
        m0_write = 1; m0_address = 13'h010; m0_writedata = 32'hCAFEBABE; m0_byteenable = 4'hF;
        #1;
        check("m0w_wait", m0_waitrequest, 0);
        check("m0w_cs",   mem_chipselect, 1);
        check("m0w_mwr",  mem_write,      1);
        check("m0w_addr", mem_address,    32'h010);
        step();
        check("m0w_rdv", m0_readdatavalid, 0);
        m0_write = 0; m0_read = 1;
        #1;
        check("m0r_wait", m0_waitrequest, 0);
        check("m0r_mwr",  mem_write,      0);
        step();
        idle();
        check("m0r_rdv0", m0_readdatavalid, 1);
        check("m0r_data", m0_readdata,      32'hCAFEBABE);
        check("m0r_rdv1", m1_readdatavalid, 0);
        check("m0r_rd1",  m1_readdata,      0);
        step();
        check("m0r_rdv0_off", m0_readdatavalid, 0);

        // m1 partial write: full 0xFFFFFFFF then lanes 1:0 of 0x12345678.
        m1_write = 1; m1_address = 13'h100; m1_writedata = 32'hFFFFFFFF; m1_byteenable = 4'hF;
        step();
        m1_writedata = 32'h12345678; m1_byteenable = 4'b0011;
        step();
        m1_write = 0; m1_read = 1;
        #1;
        check("m1r_wait", m1_waitrequest, 0);
        step();
        idle();
        check("m1r_rdv1", m1_readdatavalid, 1);
        check("m1r_data", m1_readdata,      32'hFFFF5678);
        check("m1r_rdv0", m0_readdatavalid, 0);

        // Simultaneous reads held 4 cycles: m1 was last, so m0, m1, m0, m1.
        m0_read = 1; m0_address = 13'h010;
        m1_read = 1; m1_address = 13'h100;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("tie%0d_wait0", c), m0_waitrequest, (c % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("tie%0d_wait1", c), m1_waitrequest, (c % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("tie%0d_addr", c),  mem_address,    (c % 2 == 0) ? 32'h010 : 32'h100);
            step();
            if (c == 3) idle();
            if (c % 2 == 0) begin
                check($sformatf("tie%0d_rdv0", c), m0_readdatavalid, 1);
                check($sformatf("tie%0d_rd0", c),  m0_readdata,      32'hCAFEBABE);
                check($sformatf("tie%0d_rdv1", c), m1_readdatavalid, 0);
            end else begin
                check($sformatf("tie%0d_rdv1", c), m1_readdatavalid, 1);
                check($sformatf("tie%0d_rd1", c),  m1_readdata,      32'hFFFF5678);
                check($sformatf("tie%0d_rdv0", c), m0_readdatavalid, 0);
            end
        end

        // m0 read leaves last = m0; reset lands on its accept edge and drops the strobe.
        m0_read = 1; m0_address = 13'h010;
        step();
        check("pre_rst_rdv0", m0_readdatavalid, 1);
        m1_read = 1; m1_address = 13'h100;
        @(negedge clk);
        reset_n = 0;
        #1;
        check("mid_rst_rdv0", m0_readdatavalid, 0);
        check("mid_rst_rdv1", m1_readdatavalid, 0);
        step();
        idle();
        check("mid_rst_rdv0_b", m0_readdatavalid, 0);
        check("mid_rst_cs",     mem_chipselect,   0);
        step();
        reset_n = 1;
        step();
        check("post_rst_rdv0", m0_readdatavalid, 0);
        check("post_rst_rdv1", m1_readdatavalid, 0);
        m0_read = 1; m1_read = 1;
        #1;
        check("post_tie_wait0", m0_waitrequest, 0);
        check("post_tie_wait1", m1_waitrequest, 1);
        step();
        idle();
        check("post_tie_rdv0", m0_readdatavalid, 1);
        check("post_tie_rd0",  m0_readdata,      32'hCAFEBABE);
        step();

        // Address 8000 is one past the last implemented word.
        m0_read = 1; m0_address = 13'd8000;
        #1;
        check("oor_wait0", m0_waitrequest, 0);
`ifdef MEM_ARB_RANGE_CHECK_EN
        check("oor_cs", mem_chipselect, 0);
`else
        check("oor_cs",   mem_chipselect, 1);
        check("oor_addr", mem_address,    32'd8000);
`endif
        step();
        idle();
        check("oor_rdv0", m0_readdatavalid, 1);
        check("oor_rd0",  m0_readdata,      0);
`ifdef MEM_ARB_RANGE_CHECK_EN
        check("oor_err", range_err, 1);
        repeat (3) step();
        check("oor_err_sticky", range_err, 1);
        reset_n = 0;
        #1;
        check("oor_err_rst", range_err, 0);
        step();
        reset_n = 1;
        step();
`else
        check("oor_err", range_err, 0);
        repeat (3) step();
        check("oor_err_late", range_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
